// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the serial DAC transmitter.
//   FRAME_W  : bits per serial frame sent to the DAC
//   SAMPLE_W : width of the unsigned sample carried in the frame
//   CFG      : 4-bit control nibble (channel A, unbuffered, 1x gain, active)
//   state_t  : transmitter FSM states
//   make_frame() : packs a sample behind the control nibble
// -----------------------------------------------------------------------------
package dac_pkg;

    localparam int FRAME_W  = 16;
    localparam int SAMPLE_W = 12;

    localparam logic [3:0] CFG = 4'b0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [SAMPLE_W-1:0] sample);
        return {CFG, sample};
    endfunction

endpackage

// File: rtl/sclk_strobe_gen.sv
// -----------------------------------------------------------------------------
// sclk_strobe_gen
// Phase counter for the DAC serial clock. One bit period is 2*SCLK_DIV clk
// cycles: sclk is low for the first SCLK_DIV cycles and high for the rest.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   clear   in   restart at phase 0 (start of a new frame)
//   en      in   advance the phase counter this cycle
//   sclk    out  registered serial clock level
//   bit_end out  high in the last cycle of a bit period while enabled
// -----------------------------------------------------------------------------
module sclk_strobe_gen #(
    parameter int SCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic sclk,
    output logic bit_end
);

    // 9 bits covers the largest bit period (2*255 cycles).
    localparam int PW = 9;
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * SCLK_DIV - 1);
    localparam logic [PW-1:0] PHASE_HIGH = PW'(SCLK_DIV);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;

    always_comb begin
        phase_nxt = (phase == PHASE_LAST) ? '0 : phase + PW'(1);
        bit_end   = en && (phase == PHASE_LAST);
    end

    // sclk is registered from the next phase so that it lines up with the
    // phase counter in the same cycle and never glitches on the pin.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            phase <= '0;
            sclk  <= 1'b0;
        end else if (en) begin
            phase <= phase_nxt;
            sclk  <= (phase_nxt >= PHASE_HIGH);
        end
    end

endmodule

// File: rtl/sample_dac_tx.sv
// -----------------------------------------------------------------------------
// sample_dac_tx
// Sends 12-bit samples to a serial DAC as 16-bit frames {CFG, sample}, MSB
// first, with a minimum chip-select high gap between frames.
// Parameters:
//   SCLK_DIV   dac_sclk half-period in clk cycles (1..255)
//   GAP_CYCLES dac_cs_n high time between frames in clk cycles (1..255)
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   data      in   sample to send
//   valid     in   data valid this cycle
//   ready     out  sample accepted when valid & ready
//   busy      out  frame shifting or in its gap
//   dac_sclk  out  serial clock, idles low
//   dac_sdin  out  serial data, MSB first
//   dac_cs_n  out  chip select, active low
// Build option:
//   SAMPLE_DAC_TX_BUFFER_EN  adds a one-entry holding register so a sample can
//   be accepted while a frame is in flight; it launches right after the gap.
// -----------------------------------------------------------------------------
module sample_dac_tx
    import dac_pkg::*;
#(
    parameter int SCLK_DIV   = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] data,
    input  logic                valid,
    output logic                ready,
    output logic                busy,
    output logic                dac_sclk,
    output logic                dac_sdin,
    output logic                dac_cs_n
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_W - 1);

    state_t              state;
    logic [FRAME_W-1:0]  frame_reg;
    logic [3:0]          bit_cnt;
    logic [7:0]          gap_cnt;

    logic                accept;
    logic                gap_done;
    logic                launch;
    logic                shift_en;
    logic                bit_end;
    logic [SAMPLE_W-1:0] launch_data;
    logic [FRAME_W-1:0]  launch_frame;

`ifdef SAMPLE_DAC_TX_BUFFER_EN
    logic                hold_full;
    logic                hold_full_nxt;
    logic [SAMPLE_W-1:0] hold_data;
`endif

    // A frame launches either straight from IDLE or, with the holding
    // register, at the end of a gap when a sample is waiting or arriving.
    always_comb begin
        accept   = valid && ready;
        gap_done = (state == GAP) && (gap_cnt == GAP_LAST);
        shift_en = (state == SHIFT);
`ifdef SAMPLE_DAC_TX_BUFFER_EN
        launch        = ((state == IDLE) && accept) || (gap_done && (hold_full || accept));
        launch_data   = hold_full ? hold_data : data;
        hold_full_nxt = hold_full;
        if (launch && hold_full) begin
            hold_full_nxt = 1'b0;
        end else if (accept && !launch) begin
            hold_full_nxt = 1'b1;
        end
`else
        launch      = (state == IDLE) && accept;
        launch_data = data;
`endif
        launch_frame = make_frame(launch_data);
    end

    sclk_strobe_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_strobe_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (launch),
        .en      (shift_en),
        .sclk    (dac_sclk),
        .bit_end (bit_end)
    );

    // Main FSM. All pin-facing outputs are registered. The bit counter stops
    // at the last bit so a frame can never run on into a second one; a new
    // frame always restarts it from zero on launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            frame_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            dac_cs_n  <= 1'b1;
            dac_sdin  <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
`ifdef SAMPLE_DAC_TX_BUFFER_EN
            hold_full <= 1'b0;
            hold_data <= '0;
`endif
        end else begin
            if (launch) begin
                state     <= SHIFT;
                frame_reg <= launch_frame;
                bit_cnt   <= '0;
                gap_cnt   <= '0;
                dac_cs_n  <= 1'b0;
                dac_sdin  <= launch_frame[FRAME_W-1];
                busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    SHIFT: begin
                        // sdin only moves at a bit boundary, i.e. as sclk
                        // falls back low, so it is stable across the rise.
                        if (bit_end) begin
                            if (bit_cnt == BIT_LAST) begin
                                state    <= GAP;
                                gap_cnt  <= '0;
                                dac_cs_n <= 1'b1;
                                dac_sdin <= 1'b0;
                            end else begin
                                bit_cnt  <= bit_cnt + 4'd1;
                                dac_sdin <= frame_reg[BIT_LAST - bit_cnt - 4'd1];
                            end
                        end
                    end
                    GAP: begin
                        if (gap_done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        dac_cs_n <= 1'b1;
                        dac_sdin <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end

`ifdef SAMPLE_DAC_TX_BUFFER_EN
            hold_full <= hold_full_nxt;
            if (accept && !launch) begin
                hold_data <= data;
            end
            ready <= !hold_full_nxt;
`else
            ready <= !launch && ((state == IDLE) || gap_done);
`endif
        end
    end

endmodule

// File: tb/tb_sample_dac_tx.sv
// -----------------------------------------------------------------------------
// tb_sample_dac_tx
// Drives two transmitters (SCLK_DIV=2 and SCLK_DIV=1, both GAP_CYCLES=2) from
// the same valid/data stream. A timeline model predicts every pin each cycle
// from the frame start times, and a serial monitor decodes each frame on the
// rising edges of dac_sclk and compares it with the frames the model launched.
// Honours SAMPLE_DAC_TX_BUFFER_EN for the holding-register build.
// -----------------------------------------------------------------------------
module tb_sample_dac_tx;

    localparam int G = 2;
`ifdef SAMPLE_DAC_TX_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [11:0] data;

    logic ready_a, busy_a, sclk_a, sdin_a, cs_a;
    logic ready_b, busy_b, sclk_b, sdin_b, cs_b;

    always #5 clk = ~clk;

    sample_dac_tx #(.SCLK_DIV(2), .GAP_CYCLES(G)) dut_a (
        .clk(clk), .rst(rst), .data(data), .valid(valid),
        .ready(ready_a), .busy(busy_a),
        .dac_sclk(sclk_a), .dac_sdin(sdin_a), .dac_cs_n(cs_a)
    );

    sample_dac_tx #(.SCLK_DIV(1), .GAP_CYCLES(G)) dut_b (
        .clk(clk), .rst(rst), .data(data), .valid(valid),
        .ready(ready_b), .busy(busy_b),
        .dac_sclk(sclk_b), .dac_sdin(sdin_b), .dac_cs_n(cs_b)
    );

    // Packed per DUT as {ready, busy, cs_n, sclk, sdin}.
    logic [4:0] obs [2];
    assign obs[0] = {ready_a, busy_a, cs_a, sclk_a, sdin_a};
    assign obs[1] = {ready_b, busy_b, cs_b, sclk_b, sdin_b};

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Timeline model: a frame started at cycle fs occupies 32*div cycles of
    // shifting followed by G gap cycles.
    int          div [2] = '{2, 1};
    int          fs [2];
    logic [15:0] fr [2];
    bit          pend_v [2];
    logic [11:0] pend_d [2];
    bit          m_ready [2];
    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];

    // Serial monitor state.
    bit          mon_active [2];
    logic [15:0] cap [2];
    int          nb [2];
    logic        prev_cs [2];
    logic        prev_sclk [2];

    task automatic check_output(input string tag, input logic [15:0] o, input logic [15:0] e);
        n_checks++;
        assert (o === e) else begin
            n_errors++;
            $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
        end
    endtask

    function automatic logic [4:0] expect_out(input int i);
        int t;
        int d;
        d = div[i];
        if (fs[i] < 0) return {m_ready[i], 4'b0100};
        t = cyc - fs[i];
        if (t < 32 * d) return {m_ready[i], 1'b1, 1'b0, 1'((t % (2 * d)) >= d), fr[i][15 - t / (2 * d)]};
        return {m_ready[i], 4'b1100};
    endfunction

    task automatic start_frame(input int i, input logic [11:0] d);
        fs[i] = cyc;
        fr[i] = {4'h3, d};
        if (i == 0) exp_q0.push_back(fr[i]);
        else        exp_q1.push_back(fr[i]);
    endtask

    task automatic monitor(input int i);
        logic        cs;
        logic        sc;
        logic        sd;
        logic [15:0] e;
        cs = obs[i][2];
        sc = obs[i][1];
        sd = obs[i][0];
        if (prev_cs[i] && !cs) begin
            mon_active[i] = 1'b1;
            cap[i] = '0;
            nb[i] = 0;
        end
        if (mon_active[i] && !cs && !prev_sclk[i] && sc) begin
            cap[i] = {cap[i][14:0], sd};
            nb[i]++;
        end
        if (mon_active[i] && !prev_cs[i] && cs) begin
            e = 'x;
            if (i == 0) begin
                if (exp_q0.size() > 0) e = exp_q0.pop_front();
            end else begin
                if (exp_q1.size() > 0) e = exp_q1.pop_front();
            end
            check_output($sformatf("frame%0d", i), cap[i], e);
            check_output($sformatf("nbits%0d", i), 16'(nb[i]), 16'd16);
            mon_active[i] = 1'b0;
        end
        prev_cs[i] = cs;
        prev_sclk[i] = sc;
    endtask

    // One clock cycle: present inputs, advance the model across the edge,
    // then compare every pin of both DUTs 1 time unit after the edge.
    task automatic apply_stimulus(input bit v, input logic [11:0] d);
        bit acc [2];
        bit r;
        valid = v;
        data  = d;
        r     = rst;
        for (int i = 0; i < 2; i++) acc[i] = v && m_ready[i] && !r;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                fs[i] = -1;
                pend_v[i] = 1'b0;
                m_ready[i] = 1'b0;
                mon_active[i] = 1'b0;
                if (i == 0) exp_q0.delete();
                else        exp_q1.delete();
            end else begin
                if (acc[i]) begin
                    if (fs[i] < 0) start_frame(i, d);
                    else begin
                        pend_v[i] = 1'b1;
                        pend_d[i] = d;
                    end
                end
                if (fs[i] >= 0 && cyc - fs[i] >= 32 * div[i] + G) begin
                    if (pend_v[i]) begin
                        start_frame(i, pend_d[i]);
                        pend_v[i] = 1'b0;
                    end else begin
                        fs[i] = -1;
                    end
                end
                m_ready[i] = BUF ? !pend_v[i] : (fs[i] < 0);
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output($sformatf("pins%0d", i), 16'(obs[i]), 16'(expect_out(i)));
            monitor(i);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            if (fs[0] < 0 && fs[1] < 0 && !pend_v[0] && !pend_v[1]) break;
            apply_stimulus(1'b0, 12'h000);
        end
        apply_stimulus(1'b0, 12'h000);
    endtask

    initial begin
        int acc0;
        for (int i = 0; i < 2; i++) begin
            fs[i] = -1;
            fr[i] = '0;
            pend_v[i] = 1'b0;
            pend_d[i] = '0;
            m_ready[i] = 1'b0;
            mon_active[i] = 1'b0;
            cap[i] = '0;
            nb[i] = 0;
            prev_cs[i] = 1'b1;
            prev_sclk[i] = 1'b0;
        end

        // Reset with valid present: the sample must be dropped.
        rst = 1'b1;
        for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 12'h555);
        rst = 1'b0;
        apply_stimulus(1'b0, 12'h000);
        check_output("ready_after_rst", 16'(ready_a), 16'd1);

        // A5C at cycle 0, second sample offered at cycle 5.
        acc0 = cyc;
        apply_stimulus(1'b1, 12'hA5C);
        while (cyc - acc0 < 5) apply_stimulus(1'b0, 12'h000);
        apply_stimulus(1'b1, 12'h123);
        while (cyc - acc0 < 67) begin
            apply_stimulus(1'b0, 12'h000);
            if (cyc - acc0 == 64) check_output("cs_low_64", 16'(cs_a), 16'd0);
            if (cyc - acc0 == 65) check_output("gap_cs_65", 16'(cs_a), 16'd1);
            if (cyc - acc0 == 66) begin
                check_output("gap_cs_66", 16'(cs_a), 16'd1);
                check_output("ready_66", 16'(ready_a), 16'd0);
            end
        end
`ifdef SAMPLE_DAC_TX_BUFFER_EN
        check_output("held_start_67", 16'(cs_a), 16'd0);
`else
        check_output("ready_67", 16'(ready_a), 16'd1);
        check_output("idle_cs_67", 16'(cs_a), 16'd1);
`endif
        wait_idle();

        // All-zero and all-one samples.
        apply_stimulus(1'b1, 12'h000);
        wait_idle();
        apply_stimulus(1'b1, 12'hFFF);
        wait_idle();

        // valid held high with data changing every cycle.
        for (int k = 0; k < 300; k++) apply_stimulus(1'b1, 12'(k + 256));
        wait_idle();

        // Reset during cycle 20 of a frame.
        acc0 = cyc;
        apply_stimulus(1'b1, 12'h7E1);
        while (cyc - acc0 < 20) apply_stimulus(1'b0, 12'h000);
        rst = 1'b1;
        apply_stimulus(1'b1, 12'h2AA);
        check_output("abort_cs", 16'(cs_a), 16'd1);
        check_output("abort_sclk", 16'(sclk_a), 16'd0);
        check_output("abort_busy", 16'(busy_a), 16'd0);
        rst = 1'b0;
        apply_stimulus(1'b0, 12'h000);
        check_output("ready_post_abort", 16'(ready_a), 16'd1);
        for (int k = 0; k < 80; k++) apply_stimulus(1'b0, 12'h000);

        // Random traffic.
        for (int k = 0; k < 600; k++)
            apply_stimulus($urandom_range(0, 3) == 0, 12'($urandom));
        wait_idle();

        check_output("q0_drained", 16'(exp_q0.size()), 16'd0);
        check_output("q1_drained", 16'(exp_q1.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sample_dac_tx.md
SAMPLE_DAC_TX -- requirements
Module: sample_dac_tx

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 2: dac_sclk half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: minimum dac_cs_n high time between frames, in clk cycles; legal range 1..255.
REQ-003 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port data  input  12  unsigned sample to convert.
REQ-006 SHALL have port valid  input  1  data is valid this cycle.
REQ-007 SHALL have port ready  output  1  block accepts data this cycle.
REQ-008 SHALL have port busy  output  1  high while a frame is shifting or in its gap.
REQ-009 SHALL have port dac_sclk  output  1  serial clock to the DAC; idles low.
REQ-010 SHALL have port dac_sdin  output  1  serial data to the DAC, MSB first.
REQ-011 SHALL have port dac_cs_n  output  1  DAC chip select, active low.

Function
REQ-012 SHALL accept a sample on a rising clk edge where valid and ready are both high; data is captured on that edge.
REQ-013 SHALL transmit a 16-bit frame {CFG[3:0], data[11:0]}, with CFG = 4'b0011 (channel A, unbuffered, 1x gain, active).
REQ-014 SHALL implement states IDLE, SHIFT and GAP: IDLE->SHIFT on accept; SHIFT->GAP after the 16th bit; GAP->IDLE after GAP_CYCLES cycles.
REQ-015 SHALL, if the sample was accepted in cycle N, drive dac_cs_n low and dac_sdin = frame bit 15 in cycle N+1.
REQ-016 SHALL hold each bit for 2*SCLK_DIV cycles: dac_sclk low for the first SCLK_DIV cycles, then high for SCLK_DIV cycles.
REQ-017 SHALL change dac_sdin only while dac_sclk is low, so the DAC latches the bit on the rising edge of dac_sclk.
REQ-018 SHALL occupy exactly 32*SCLK_DIV cycles in SHIFT; in GAP, dac_cs_n = 1, dac_sclk = 0 and dac_sdin = 0.
REQ-019 SHALL, without the buffer option, drive ready = 1 only in IDLE.
REQ-020 SHALL drive busy = 1 in SHIFT and GAP, and busy = 0 in IDLE.
REQ-021 SHALL ignore a change of data or a drop of valid while ready is low; no sample is lost and none is duplicated.
REQ-022 SHALL use a bit counter that saturates at the frame end and never wraps into a second frame.

Reset
REQ-023 SHALL, on any clk edge with rst high, set: state = IDLE, dac_cs_n = 1, dac_sclk = 0, dac_sdin = 0, busy = 0, ready = 0, counters = 0, buffer empty.
REQ-024 SHALL abort a frame when reset is asserted mid-frame; it SHALL NOT resume after reset is released.
REQ-025 SHALL discard any valid input present in a cycle where rst is high.
REQ-026 SHALL drive ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, when SAMPLE_DAC_TX_BUFFER_EN is defined, include a one-entry holding register; ready = !holding_full in every state.
REQ-028 SHALL, with the buffer option, start a held sample with dac_cs_n low in the cycle after GAP ends, skipping IDLE.
REQ-029 SHALL, if the block is in IDLE and the holding register is empty, send a sample accepted into the buffer path directly, exactly as in REQ-015.
REQ-030 SHALL, when SAMPLE_DAC_TX_BUFFER_EN is undefined, contain no holding-register logic and behave exactly as REQ-019.

Structure
REQ-031 SHALL take the CFG constant, the frame width (16), the sample width (12) and the state enum from shared package dac_pkg.
REQ-032 SHALL place the dac_sclk phase counter and the bit-boundary strobe in sub-module sclk_strobe_gen, parameterised by SCLK_DIV.

Verification
REQ-033 SHALL cover: SCLK_DIV=2, GAP_CYCLES=2, data=12'hA5C accepted at cycle 0 -> dac_cs_n low over cycles 1..64; 16 rising edges of dac_sclk sample 16'h3A5C; ready high again at cycle 67.
REQ-034 SHALL cover: valid held high continuously with data incrementing each cycle -> only the samples present on ready&valid edges are sent, with no duplicates.
REQ-035 SHALL cover: rst asserted at cycle 20 of a frame -> on the next edge dac_cs_n = 1, dac_sclk = 0, busy = 0; ready = 1 one cycle after rst deasserts.
REQ-036 SHALL cover: SCLK_DIV=1, data=12'hFFF -> each dac_sclk high/low phase lasts 1 cycle; frame reads 16'h3FFF.
REQ-037 SHALL cover, with SAMPLE_DAC_TX_BUFFER_EN: a second sample accepted at cycle 5 -> its frame starts at cycle 67 with dac_cs_n high for exactly GAP_CYCLES between the two frames.
REQ-038 SHALL cover: data=12'h000 -> frame reads 16'h3000; dac_sdin = 0 after bit 12.
